// File: rtl/mem_rr_pkg.sv
// Shared defaults, request/response payload types and the address range helper
// used by the multi-read memory tile and its neighbours on the NoC side.
package mem_rr_pkg;

  localparam int WIDTH_DEF  = 8;
  localparam int DEPTH_DEF  = 16;
  localparam int NRD_DEF    = 2;
  localparam int MAX_ADDR_W = 16;
  localparam int MAX_WIDTH  = 64;

  // Payloads are sized for the widest tile so one type serves every instance.
  typedef struct packed {
    logic [MAX_ADDR_W-1:0] addr;
  } rd_req_t;

  typedef struct packed {
    logic [MAX_WIDTH-1:0] data;
  } rd_rsp_t;

  function automatic logic addr_ok(input logic [MAX_ADDR_W-1:0] addr,
                                   input int unsigned depth);
    return 32'(addr) < depth;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the priority
// pointer; the pointer moves past the winner only when the grant is taken.
module rr_arbiter
  import mem_rr_pkg::*;
#(
  parameter int N = NRD_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] win;
  logic          any;
  int            idx;

  always_comb begin
    grant = '0;
    win   = '0;
    any   = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        win        = PW'(idx);
      end
    end
    ptr_d = ptr_q;
    if (advance && any) begin
      ptr_d = (int'(win) + 1 >= N) ? '0 : PW'(int'(win) + 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mem_rr_multiread.sv
// Word memory with one write channel and NRD round-robin arbitrated read
// channels, each returning data through a registered, backpressure-holding slot.
module mem_rr_multiread
  import mem_rr_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int NRD    = NRD_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic [NRD-1:0]        rd_req_valid,
  output logic [NRD-1:0]        rd_req_ready,
  input  logic [NRD*ADDR_W-1:0] rd_req_addr,
  output logic [NRD-1:0]        rd_rsp_valid,
  input  logic [NRD-1:0]        rd_rsp_ready,
  output logic [NRD*WIDTH-1:0]  rd_rsp_data,
  output logic                  oob_err
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; a valid side holds its payload until then, ready may depend
  // combinationally on valid (read grants do), valid never depends on ready.

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             wr_fire, wr_in_range;
  rd_req_t          req [NRD];
  logic [NRD-1:0]   eligible, grant;
  logic             rd_advance;
  logic [NRD-1:0]   rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q [NRD];
  logic [WIDTH-1:0] rsp_data_d [NRD];
  logic             oob_q, oob_d;

  assign wr_ready = rst_n;

  always_comb begin
    wr_fire     = wr_valid && wr_ready;
    wr_in_range = addr_ok(MAX_ADDR_W'(wr_addr), DEPTH);
    eligible    = '0;
    for (int i = 0; i < NRD; i++) begin
      req[i].addr = MAX_ADDR_W'(rd_req_addr[i*ADDR_W +: ADDR_W]);
      // A slot being drained this cycle can take the next word without a bubble.
      eligible[i] = rd_req_valid[i] && (!rsp_valid_q[i] || rd_rsp_ready[i]);
    end
  end

  assign rd_advance = |grant;

  rr_arbiter #(.N(NRD)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (eligible),
    .advance (rd_advance),
    .grant   (grant)
  );

  always_comb begin
    oob_d = oob_q || (wr_fire && !wr_in_range);
    for (int i = 0; i < NRD; i++) begin
      rsp_valid_d[i] = rsp_valid_q[i] && !rd_rsp_ready[i];
      rsp_data_d[i]  = rsp_data_q[i];
      if (grant[i]) begin
        rsp_valid_d[i] = 1'b1;
        if (addr_ok(req[i].addr, DEPTH)) begin
          // Same-edge write to the read address wins: return the incoming word.
          if (wr_fire && wr_in_range && (wr_addr == req[i].addr[ADDR_W-1:0]))
            rsp_data_d[i] = wr_data;
          else
            rsp_data_d[i] = mem_q[req[i].addr[ADDR_W-1:0]];
        end else begin
          rsp_data_d[i] = '0;
          oob_d         = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire && wr_in_range) mem_q[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= '0;
      oob_q       <= 1'b0;
      for (int i = 0; i < NRD; i++) rsp_data_q[i] <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      oob_q       <= oob_d;
      for (int i = 0; i < NRD; i++) rsp_data_q[i] <= rsp_data_d[i];
    end
  end

  assign rd_req_ready = grant;
  assign rd_rsp_valid = rsp_valid_q;
  assign oob_err      = oob_q;

  always_comb begin
    rd_rsp_data = '0;
    for (int i = 0; i < NRD; i++) rd_rsp_data[i*WIDTH +: WIDTH] = rsp_data_q[i];
  end

endmodule

// File: tb/tb_mem_rr_multiread.sv
// Randomised and directed checks of mem_rr_multiread (WIDTH=8, DEPTH=12, NRD=2)
// against a word-level reference model of the memory, slots and arbitration.
module tb_mem_rr_multiread;

  localparam int WIDTH  = 8;
  localparam int DEPTH  = 12;
  localparam int ADDR_W = 4;
  localparam int NRD    = 2;

  logic                  clk;
  logic                  rst_n;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [ADDR_W-1:0]     wr_addr;
  logic [WIDTH-1:0]      wr_data;
  logic [NRD-1:0]        rd_req_valid;
  logic [NRD-1:0]        rd_req_ready;
  logic [NRD*ADDR_W-1:0] rd_req_addr;
  logic [NRD-1:0]        rd_rsp_valid;
  logic [NRD-1:0]        rd_rsp_ready;
  logic [NRD*WIDTH-1:0]  rd_rsp_data;
  logic                  oob_err;

  mem_rr_multiread #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .NRD(NRD)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .rd_req_valid (rd_req_valid),
    .rd_req_ready (rd_req_ready),
    .rd_req_addr  (rd_req_addr),
    .rd_rsp_valid (rd_rsp_valid),
    .rd_rsp_ready (rd_rsp_ready),
    .rd_rsp_data  (rd_rsp_data),
    .oob_err      (oob_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model
  logic [WIDTH-1:0] m_mem [DEPTH];
  logic [NRD-1:0]   m_valid;
  logic [WIDTH-1:0] m_data [NRD];
  int               m_ptr;
  logic             m_oob;
  logic [NRD-1:0]   obs_grant, exp_grant;
  logic [NRD-1:0]   exp_q [$];

  task automatic model_reset();
    m_valid = '0;
    m_ptr   = 0;
    m_oob   = 1'b0;
    for (int i = 0; i < NRD; i++) m_data[i] = '0;
  endtask

  task automatic idle_inputs();
    wr_valid     = 1'b0;
    wr_addr      = '0;
    wr_data      = '0;
    rd_req_valid = '0;
    rd_req_addr  = '0;
    rd_rsp_ready = '0;
  endtask

  // driver: called at a falling edge, returns at the next falling edge
  task automatic apply(input logic wv, input logic [ADDR_W-1:0] wa, input logic [WIDTH-1:0] wd,
                       input logic [NRD-1:0] rv, input logic [ADDR_W-1:0] ra0,
                       input logic [ADDR_W-1:0] ra1, input logic [NRD-1:0] rr);
    logic [ADDR_W-1:0] ra [NRD];
    logic [NRD-1:0]    elig;
    int                g;
    int                c;
    wr_valid     = wv;
    wr_addr      = wa;
    wr_data      = wd;
    rd_req_valid = rv;
    rd_req_addr  = {ra1, ra0};
    rd_rsp_ready = rr;
    ra[0] = ra0;
    ra[1] = ra1;
    #1;
    obs_grant = rd_req_ready;
    for (int i = 0; i < NRD; i++) elig[i] = rv[i] && (!m_valid[i] || rr[i]);
    g = -1;
    for (int k = 0; k < NRD; k++) begin
      c = (m_ptr + k) % NRD;
      if (g < 0 && elig[c]) g = c;
    end
    exp_grant = '0;
    if (g >= 0) exp_grant[g] = 1'b1;
    @(posedge clk);
    for (int i = 0; i < NRD; i++) if (rr[i]) m_valid[i] = 1'b0;
    if (g >= 0) begin
      m_valid[g] = 1'b1;
      if (int'(ra[g]) < DEPTH) m_data[g] = (wv && wa == ra[g]) ? wd : m_mem[ra[g]];
      else begin
        m_data[g] = '0;
        m_oob     = 1'b1;
      end
      m_ptr = (g + 1) % NRD;
    end
    if (wv) begin
      if (int'(wa) < DEPTH) m_mem[wa] = wd;
      else m_oob = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (rd_rsp_valid !== 2'b00 || rd_rsp_data !== 16'h0000 || oob_err !== 1'b0 || wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got valid=%b data=%h oob=%b wr_ready=%b expected 00 0000 0 0",
               rd_rsp_valid, rd_rsp_data, oob_err, wr_ready);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL wr_ready_after_reset: got %b expected 1", wr_ready);
    end
    @(negedge clk);
    // fill the array so every later read has a known answer
    for (int a = 0; a < DEPTH; a++) begin
      apply(1'b1, ADDR_W'(a), (a == 5) ? 8'h11 : WIDTH'($urandom_range(0, 255)), 2'b00, '0, '0, 2'b00);
    end
    apply(1'b0, '0, '0, 2'b11, 4'd1, 4'd2, 2'b11);
    checks++;
    if (obs_grant !== 2'b01) begin
      errors++;
      $display("FAIL ptr_after_reset: got grant %b expected 01", obs_grant);
    end
  endtask

  task automatic test_basic_readback();
    apply(1'b1, 4'd3, 8'hA5, 2'b00, '0, '0, 2'b11);
    apply(1'b0, '0, '0, 2'b01, 4'd3, 4'd0, 2'b11);
    checks++;
    if (obs_grant !== 2'b01 || rd_rsp_valid[0] !== 1'b1 || rd_rsp_data[7:0] !== 8'hA5) begin
      errors++;
      $display("FAIL basic_readback: got grant=%b valid0=%b data0=%h expected 01 1 a5",
               obs_grant, rd_rsp_valid[0], rd_rsp_data[7:0]);
    end
  endtask

  task automatic test_write_first();
    apply(1'b1, 4'd5, 8'h3C, 2'b10, 4'd0, 4'd5, 2'b11);
    checks++;
    if (obs_grant !== 2'b10 || rd_rsp_valid[1] !== 1'b1 || rd_rsp_data[15:8] !== 8'h3C) begin
      errors++;
      $display("FAIL write_first: got grant=%b valid1=%b data1=%h expected 10 1 3c",
               obs_grant, rd_rsp_valid[1], rd_rsp_data[15:8]);
    end
  endtask

  task automatic test_round_robin();
    logic [NRD-1:0] want;
    exp_q.delete();
    for (int n = 0; n < 6; n++) exp_q.push_back((n % 2 == 0) ? 2'b01 : 2'b10);
    for (int n = 0; n < 6; n++) begin
      apply(1'b0, '0, '0, 2'b11, ADDR_W'($urandom_range(0, DEPTH-1)),
            ADDR_W'($urandom_range(0, DEPTH-1)), 2'b11);
      want = exp_q.pop_front();
      checks++;
      if (obs_grant !== want || rd_rsp_valid !== want || rd_rsp_data !== {m_data[1], m_data[0]}) begin
        errors++;
        $display("FAIL round_robin[%0d]: got grant=%b valid=%b data=%h expected %b %b %h",
                 n, obs_grant, rd_rsp_valid, rd_rsp_data, want, want, {m_data[1], m_data[0]});
      end
    end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] held;
    apply(1'b0, '0, '0, 2'b01, 4'd7, 4'd0, 2'b00);
    held = m_mem[7];
    checks++;
    if (rd_rsp_valid[0] !== 1'b1 || rd_rsp_data[7:0] !== held) begin
      errors++;
      $display("FAIL bp_first: got valid0=%b data0=%h expected 1 %h", rd_rsp_valid[0], rd_rsp_data[7:0], held);
    end
    for (int n = 0; n < 4; n++) begin
      apply(1'b0, '0, '0, 2'b11, 4'd7, ADDR_W'($urandom_range(0, DEPTH-1)), 2'b10);
      checks++;
      if (obs_grant !== 2'b10 || rd_rsp_valid !== 2'b11 || rd_rsp_data[7:0] !== held ||
          rd_rsp_data[15:8] !== m_data[1]) begin
        errors++;
        $display("FAIL backpressure[%0d]: got grant=%b valid=%b data=%h expected 10 11 %h%h",
                 n, obs_grant, rd_rsp_valid, rd_rsp_data, m_data[1], held);
      end
    end
    apply(1'b0, '0, '0, 2'b00, '0, '0, 2'b11);
    checks++;
    if (rd_rsp_valid !== 2'b00 || rd_rsp_data[7:0] !== held) begin
      errors++;
      $display("FAIL bp_drain: got valid=%b data0=%h expected 00 %h", rd_rsp_valid, rd_rsp_data[7:0], held);
    end
  endtask

  task automatic test_out_of_range();
    apply(1'b1, 4'd13, 8'h77, 2'b00, '0, '0, 2'b11);
    checks++;
    if (oob_err !== 1'b1) begin
      errors++;
      $display("FAIL oob_write: got oob=%b expected 1", oob_err);
    end
    for (int a = 0; a < DEPTH; a++) begin
      apply(1'b0, '0, '0, 2'b01, ADDR_W'(a), '0, 2'b11);
      checks++;
      if (rd_rsp_valid[0] !== 1'b1 || rd_rsp_data[7:0] !== m_mem[a]) begin
        errors++;
        $display("FAIL oob_array_intact[%0d]: got valid0=%b data0=%h expected 1 %h",
                 a, rd_rsp_valid[0], rd_rsp_data[7:0], m_mem[a]);
      end
    end
    apply(1'b0, '0, '0, 2'b10, '0, 4'd14, 2'b11);
    checks++;
    if (rd_rsp_valid[1] !== 1'b1 || rd_rsp_data[15:8] !== 8'h00 || oob_err !== 1'b1) begin
      errors++;
      $display("FAIL oob_read: got valid1=%b data1=%h oob=%b expected 1 00 1",
               rd_rsp_valid[1], rd_rsp_data[15:8], oob_err);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      apply(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 15)), WIDTH'($urandom_range(0, 255)),
            NRD'($urandom_range(0, 3)), ADDR_W'($urandom_range(0, 15)), ADDR_W'($urandom_range(0, 15)),
            NRD'($urandom_range(0, 3)));
      checks++;
      if (obs_grant !== exp_grant || rd_rsp_valid !== m_valid ||
          rd_rsp_data !== {m_data[1], m_data[0]} || oob_err !== m_oob) begin
        errors++;
        $display("FAIL random[%0d]: got grant=%b valid=%b data=%h oob=%b expected %b %b %h %b",
                 n, obs_grant, rd_rsp_valid, rd_rsp_data, oob_err,
                 exp_grant, m_valid, {m_data[1], m_data[0]}, m_oob);
      end
    end
  endtask

  task automatic test_reset_mid();
    apply(1'b0, '0, '0, 2'b00, '0, '0, 2'b11);
    apply(1'b0, '0, '0, 2'b11, 4'd2, 4'd9, 2'b00);
    apply(1'b0, '0, '0, 2'b11, 4'd2, 4'd9, 2'b00);
    checks++;
    if (rd_rsp_valid !== 2'b11) begin
      errors++;
      $display("FAIL mid_setup: got valid=%b expected 11", rd_rsp_valid);
    end
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (rd_rsp_valid !== 2'b00 || rd_rsp_data !== 16'h0000 || oob_err !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_async: got valid=%b data=%h oob=%b expected 00 0000 0",
               rd_rsp_valid, rd_rsp_data, oob_err);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    apply(1'b0, '0, '0, 2'b11, 4'd9, 4'd2, 2'b11);
    checks++;
    if (obs_grant !== 2'b01 || rd_rsp_valid !== 2'b01 || rd_rsp_data[7:0] !== m_mem[9]) begin
      errors++;
      $display("FAIL after_mid_reset: got grant=%b valid=%b data0=%h expected 01 01 %h",
               obs_grant, rd_rsp_valid, rd_rsp_data[7:0], m_mem[9]);
    end
    apply(1'b0, '0, '0, 2'b11, 4'd9, 4'd2, 2'b11);
    checks++;
    if (obs_grant !== 2'b10 || rd_rsp_data[15:8] !== m_mem[2]) begin
      errors++;
      $display("FAIL after_mid_reset_ch1: got grant=%b data1=%h expected 10 %h",
               obs_grant, rd_rsp_data[15:8], m_mem[2]);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_basic_readback();
    test_write_first();
    test_round_robin();
    test_backpressure();
    test_out_of_range();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_rr_multiread.md
Name: mem_rr_multiread

Overview:
- Clocked, parametrised successor to the single-port CSP memory tile used for CNN weight and ifmap storage.
- One write channel and NRD independent read channels, each using valid/ready handshakes.
- A round-robin arbiter grants at most one read per cycle.
- Each read channel has a registered response slot that holds under backpressure.
- Sits between the NoC packet decoder and the PE-side filter/ifmap fetch logic.

Parameters:
WIDTH, 8, data word width in bits
DEPTH, 16, number of words; need not be a power of two
ADDR_W, $clog2(DEPTH), address width; must be at least 1
NRD, 2, number of read channels, 1..8

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
wr_valid  in  1  write request valid
wr_ready  out  1  write request ready
wr_addr  in  ADDR_W  write address
wr_data  in  WIDTH  write data
rd_req_valid  in  NRD  per-channel read request valid
rd_req_ready  out  NRD  per-channel grant, combinational
rd_req_addr  in  NRD*ADDR_W  per-channel read address; channel i at slice [i*ADDR_W +: ADDR_W]
rd_rsp_valid  out  NRD  per-channel response valid
rd_rsp_ready  in  NRD  per-channel response accept
rd_rsp_data  out  NRD*WIDTH  per-channel response data; channel i at slice [i*WIDTH +: WIDTH]
oob_err  out  1  sticky out-of-range access flag

Behaviour:
- Reset state:
  - rd_rsp_valid = 0, rd_rsp_data = 0, oob_err = 0.
  - Arbiter priority pointer = 0.
  - Memory array is not reset; it retains its contents across reset.
- Write channel:
  - wr_ready is tied to 1 after reset and is 0 while rst_n is low.
  - A write fires when wr_valid && wr_ready; the array updates at that edge.
  - If wr_addr >= DEPTH, the write is dropped and oob_err is set.
- Read eligibility: channel i is eligible when rd_req_valid[i] = 1 and its response slot is free.
  - Free means rd_rsp_valid[i] = 0, or rd_rsp_ready[i] = 1 in the same cycle (pass-through, no bubble).
- Arbitration:
  - Among eligible channels, grant the first at or after the pointer, wrapping modulo NRD.
  - rd_req_ready is one-hot or zero.
  - After a grant to channel g, the pointer becomes (g+1) mod NRD.
  - The pointer is unchanged when there is no grant.
- Read latency: exactly 1 cycle.
  - A grant at edge N sets rd_rsp_valid[g] and rd_rsp_data[g] after edge N.
  - The slot holds valid and data stable until rd_rsp_ready[g] is sampled high.
- Simultaneous write and granted read to the same in-range address: write-first; the response carries the new wr_data.
- Out-of-range read (addr >= DEPTH): the response is still issued with data 0, and oob_err is set.
- oob_err clears only on reset.
- Response accept without a new grant: rd_rsp_valid[i] drops to 0 on the next edge; data is held.
- Reset asserted mid-operation:
  - All pending responses are discarded immediately (asynchronous clear).
  - Requests in flight are lost; requesters must reissue them.
  - The array is retained.
- Ungranted requests: the requester must hold rd_req_valid and rd_req_addr stable until rd_req_ready. Holding is not checked by the design.

Decomposition:
- Package mem_rr_pkg holds:
  - localparam defaults;
  - typedef rd_req_t {addr};
  - typedef rd_rsp_t {data}.
- Sub-module rr_arbiter #(N):
  - ports req[N], grant[N] (one-hot), advance (grant taken);
  - holds the priority pointer;
  - reusable by the NoC router output ports.
- Top level holds the array, the write path, per-channel response registers and the oob logic.

Test Plan:
- Basic read-back: write 0xA5 to addr 3, then read on channel 0 -> rd_rsp_valid[0] = 1 one cycle after grant, data 0xA5.
- Write-first collision: write 0x3C to addr 5 in the same cycle as a channel 1 read of addr 5 (old value 0x11) -> response 0x3C.
- Round-robin fairness (NRD=2): both channels request continuously with rd_rsp_ready tied high -> grants alternate 0,1,0,1; each channel gets one response per 2 cycles.
- Backpressure: channel 0 response pending with rd_rsp_ready[0] = 0 for 4 cycles -> data stable, channel 0 gets no grant, channel 1 is granted every cycle.
- Out of range (DEPTH=12): write to addr 13 -> array unchanged, oob_err = 1. Read of addr 14 -> data 0, oob_err stays 1.
- Reset mid-operation: assert rst_n low while rd_rsp_valid = 2'b11 -> outputs clear immediately. After release, a read of a previously written addr returns its old value and the pointer restarts at channel 0.
